// File: rtl/seq_multiplier_nb.sv
// Sequential shift-and-add multiplier with valid/ready handshakes on both sides.
// Signed operands are multiplied as magnitudes; the sign is applied when the product is registered.
module seq_multiplier_nb #(
    parameter int unsigned N = 8,
    parameter int unsigned K = 2 * N
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         signed_mode,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [K-1:0] Out,
    output logic         busy
);

    localparam int unsigned CntW = $clog2(N + 1);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e          state_q, state_d;
    logic [K-1:0]    mcand_q, mcand_d;
    logic [N-1:0]    mplier_q, mplier_d;
    logic            sign_q, sign_d;
    logic [K-1:0]    acc_q, acc_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [K-1:0]    out_q, out_d;
    logic [N-1:0]    mag_a, mag_b;

    // -2^(N-1) negates to itself, which read as unsigned is the correct magnitude.
    always_comb begin
        mag_a = (signed_mode && A[N-1]) ? -A : A;
        mag_b = (signed_mode && B[N-1]) ? -B : B;
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        sign_d   = sign_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    mcand_d  = {{(K-N){1'b0}}, mag_a};
                    mplier_d = mag_b;
                    sign_d   = signed_mode & (A[N-1] ^ B[N-1]);
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = StCalc;
                end
            end
            StCalc: begin
                // Extra cycle after the N-th iteration registers the signed result.
                if (cnt_q == CntW'(N)) begin
                    out_d   = sign_q ? -acc_q : acc_q;
                    state_d = StDone;
                end else begin
                    if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + 1'b1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            mcand_q  <= '0;
            mplier_q <= '0;
            sign_q   <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            out_q    <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            sign_q   <= sign_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
        end
    end

    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        busy      = (state_q == StCalc);
        Out       = out_q;
    end

endmodule

// File: tb/tb_seq_multiplier_nb.sv
// Bench for seq_multiplier_nb: directed vectors on N=4 and N=8 instances, handshake corner
// cases, and a randomized back-to-back run against an arithmetic reference.
module tb_seq_multiplier_nb;

    logic        clk = 1'b0;
    logic        rst;
    logic        sm;
    logic        ord;
    logic        iv4, iv8;
    logic [7:0]  a_in, b_in;
    logic        ir4, ov4, busy4;
    logic [7:0]  out4;
    logic        ir8, ov8, busy8;
    logic [15:0] out8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_multiplier_nb #(.N(4)) dut4 (
        .clk(clk), .reset(rst), .in_valid(iv4), .in_ready(ir4), .signed_mode(sm),
        .A(a_in[3:0]), .B(b_in[3:0]), .out_valid(ov4), .out_ready(ord), .Out(out4),
        .busy(busy4)
    );

    seq_multiplier_nb #(.N(8)) dut8 (
        .clk(clk), .reset(rst), .in_valid(iv8), .in_ready(ir8), .signed_mode(sm),
        .A(a_in), .B(b_in), .out_valid(ov8), .out_ready(ord), .Out(out8),
        .busy(busy8)
    );

    logic        sel;
    logic        cur_ir, cur_ov, cur_busy;
    logic [15:0] cur_out;
    assign cur_ir   = sel ? ir8 : ir4;
    assign cur_ov   = sel ? ov8 : ov4;
    assign cur_busy = sel ? busy8 : busy4;
    assign cur_out  = sel ? out8 : {8'h00, out4};

    typedef struct {
        bit          w;
        bit          s;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] ref_mul8(input bit s, input logic [7:0] a, input logic [7:0] b);
        int va, vb;
        va = s ? int'($signed(a)) : int'(a);
        vb = s ? int'($signed(b)) : int'(b);
        return 16'(va * vb);
    endfunction

    function automatic logic [7:0] rnd8();
        case ($urandom_range(0, 9))
            0:       return 8'h80;
            1:       return 8'h7F;
            2:       return 8'hFF;
            3:       return 8'h00;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic start_op(input bit w, input bit s, input logic [7:0] a, input logic [7:0] b);
        int t = 0;
        sel = w;
        while (!cur_ir && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("in_ready_before_accept", 32'(cur_ir), 32'd1);
        sm   = s;
        a_in = a;
        b_in = b;
        if (w) iv8 = 1'b1;
        else   iv4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv4 = 1'b0;
        iv8 = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!cur_ov && lat < 40) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic finish_op();
        ord = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ord = 1'b0;
        chk("out_valid_after_handshake", 32'(cur_ov), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int seen;
        int accepted;
        int results;
        int cyc;
        logic [15:0] q[$];

        tbl[0] = '{1'b0, 1'b0, 8'h0F, 8'h0F, 16'h00E1};
        tbl[1] = '{1'b0, 1'b1, 8'h08, 8'h08, 16'h0040};
        tbl[2] = '{1'b0, 1'b1, 8'h08, 8'h07, 16'h00C8};
        tbl[3] = '{1'b1, 1'b1, 8'h7F, 8'h81, 16'hC0FF};
        tbl[4] = '{1'b1, 1'b1, 8'h00, 8'h81, 16'h0000};
        tbl[5] = '{1'b1, 1'b0, 8'hFF, 8'hFF, 16'hFE01};
        tbl[6] = '{1'b1, 1'b1, 8'h80, 8'h80, 16'h4000};
        tbl[7] = '{1'b1, 1'b1, 8'hFF, 8'h01, 16'hFFFF};
        tbl[8] = '{1'b0, 1'b1, 8'h0F, 8'h07, 16'h00F9};
        tbl[9] = '{1'b1, 1'b0, 8'h81, 8'h02, 16'h0102};

        rst = 1'b1; sm = 1'b0; ord = 1'b0; iv4 = 1'b0; iv8 = 1'b0;
        a_in = '0; b_in = '0; sel = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready4", 32'(ir4), 32'd1);
        chk("rst_out_valid4", 32'(ov4), 32'd0);
        chk("rst_out4", 32'(out4), 32'd0);
        chk("rst_busy4", 32'(busy4), 32'd0);
        chk("rst_in_ready8", 32'(ir8), 32'd1);
        chk("rst_out_valid8", 32'(ov8), 32'd0);
        chk("rst_out8", 32'(out8), 32'd0);

        for (int i = 0; i < 10; i++) begin
            start_op(tbl[i].w, tbl[i].s, tbl[i].a, tbl[i].b);
            chk("busy_after_accept", 32'(cur_busy), 32'd1);
            wait_done(lat);
            chk("latency", 32'(lat), tbl[i].w ? 32'd9 : 32'd5);
            chk("table_product", 32'(cur_out), 32'(tbl[i].exp));
            chk("busy_in_done", 32'(cur_busy), 32'd0);
            finish_op();
        end

        // Consumer stalls in DONE while the producer keeps pulsing in_valid.
        start_op(1'b1, 1'b0, 8'd200, 8'd3);
        wait_done(lat);
        chk("stall_latency", 32'(lat), 32'd9);
        chk("stall_product", 32'(out8), 32'd600);
        for (int i = 0; i < 10; i++) begin
            iv8  = i[0];
            a_in = 8'($urandom);
            b_in = 8'($urandom);
            @(posedge clk);
            @(negedge clk);
            chk("stall_out_valid", 32'(ov8), 32'd1);
            chk("stall_out", 32'(out8), 32'd600);
            chk("stall_in_ready", 32'(ir8), 32'd0);
        end
        iv8 = 1'b1; sm = 1'b0; a_in = 8'd7; b_in = 8'd9; ord = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ord = 1'b0;
        chk("bubble_out_valid", 32'(ov8), 32'd0);
        chk("bubble_in_ready", 32'(ir8), 32'd1);
        chk("bubble_busy", 32'(busy8), 32'd0);
        chk("bubble_out_retained", 32'(out8), 32'd600);
        @(posedge clk);
        @(negedge clk);
        iv8 = 1'b0;
        chk("post_bubble_busy", 32'(busy8), 32'd1);
        chk("post_bubble_in_ready", 32'(ir8), 32'd0);
        wait_done(lat);
        chk("post_bubble_latency", 32'(lat), 32'd9);
        chk("post_bubble_product", 32'(out8), 32'd63);
        finish_op();

        // Reset on the second CALC cycle aborts the operation.
        start_op(1'b0, 1'b0, 8'd15, 8'd15);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_in_ready", 32'(ir4), 32'd1);
        chk("abort_out_valid", 32'(ov4), 32'd0);
        chk("abort_out", 32'(out4), 32'd0);
        chk("abort_busy", 32'(busy4), 32'd0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (ov4) seen++;
        end
        chk("abort_no_out_valid", 32'(seen), 32'd0);
        start_op(1'b0, 1'b0, 8'd3, 8'd5);
        wait_done(lat);
        chk("fresh_latency", 32'(lat), 32'd5);
        chk("fresh_product", 32'(out4), 32'd15);
        finish_op();

        // Randomized back-to-back traffic with random consumer back-pressure.
        sel = 1'b1;
        accepted = 0;
        results = 0;
        cyc = 0;
        while (results < 1000 && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            iv8  = (accepted < 1000) && ($urandom_range(0, 3) != 0);
            sm   = 1'($urandom);
            a_in = rnd8();
            b_in = rnd8();
            ord  = ($urandom_range(0, 2) != 0);
            if (ov8 && ord) begin
                if (q.size() == 0) begin
                    chk("rand_spurious_result", 32'(q.size()), 32'd1);
                end else begin
                    chk("rand_product", 32'(out8), 32'(q.pop_front()));
                end
                results++;
            end
            if (iv8 && ir8) begin
                q.push_back(ref_mul8(sm, a_in, b_in));
                accepted++;
            end
        end
        @(negedge clk);
        iv8 = 1'b0;
        ord = 1'b0;
        chk("rand_result_count", 32'(results), 32'd1000);
        chk("rand_queue_empty", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
